la_capture_core: RTL and testbench

LA_CAPTURE_CORE -- requirements
Module: la_capture_core

---
 rtl/la_pkg.sv | 27 ++
 rtl/la_capture_core_if.sv | 32 +++
 rtl/la_capture_ram.sv | 34 +++
 rtl/la_capture_core.sv | 224 ++++++++++++++++++++++
 tb/tb_la_capture_core.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/la_pkg.sv
// -----------------------------------------------------------------------------
// la_pkg -- shared types for the logic-analyser capture core.
//   la_state_e     : capture FSM state, encoded IDLE=0 .. DONE=4 (visible on state_o)
//   la_trig_mode_e : trigger mode, encoded as the trig_mode_i input
// -----------------------------------------------------------------------------
package la_pkg;

    localparam int unsigned LA_STATE_W   = 3;
    localparam int unsigned LA_MODE_W    = 2;
    localparam int unsigned LA_TRIG_CNTW = 8;

    typedef enum logic [LA_STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } la_state_e;

    typedef enum logic [LA_MODE_W-1:0] {
        TRIG_LEVEL = 2'd0,
        TRIG_RISE  = 2'd1,
        TRIG_FALL  = 2'd2,
        TRIG_ANY   = 2'd3
    } la_trig_mode_e;

endpackage

// File: rtl/la_capture_core_if.sv
// -----------------------------------------------------------------------------
// la_capture_core_if -- sample RAM bus between the capture core and its RAM.
//   we / waddr / wdata : write port (one sample per cycle)
//   re / raddr         : read request
//   rdata              : registered read data, valid the cycle after re
// modport master : capture control side
// modport slave  : RAM side
// -----------------------------------------------------------------------------
interface la_capture_core_if #(
    parameter int PROBE_W = 7,
    parameter int DEPTH   = 1024
);
    localparam int AW = $clog2(DEPTH);

    logic               we;
    logic [AW-1:0]      waddr;
    logic [PROBE_W-1:0] wdata;
    logic               re;
    logic [AW-1:0]      raddr;
    logic [PROBE_W-1:0] rdata;

    modport master (
        output we, waddr, wdata, re, raddr,
        input  rdata
    );

    modport slave (
        input  we, waddr, wdata, re, raddr,
        output rdata
    );

endinterface

// File: rtl/la_capture_ram.sv
// -----------------------------------------------------------------------------
// la_capture_ram -- simple dual-port sample store, DEPTH x PROBE_W.
//   clk_i   : clock
//   rst_n_i : asynchronous active-low reset (read register only; the array
//             keeps its contents across reset)
//   bus     : la_capture_core_if.slave -- one write port, one registered read
//             port; rdata holds its value while re is low
// -----------------------------------------------------------------------------
module la_capture_ram #(
    parameter int PROBE_W = 7,
    parameter int DEPTH   = 1024
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    la_capture_core_if.slave bus
);

    logic [PROBE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (bus.we) begin
            mem[bus.waddr] <= bus.wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bus.rdata <= '0;
        end else if (bus.re) begin
            bus.rdata <= mem[bus.raddr];
        end
    end

endmodule

// File: rtl/la_capture_core.sv
// -----------------------------------------------------------------------------
// la_capture_core -- logic-analyser capture engine with pre-trigger history.
//
// Ports
//   clk_i, rst_n_i         : sample clock, asynchronous active-low reset
//   probe_i                : sampled signals
//   arm_i                  : one-cycle start pulse; latches trigger config
//   trig_mode_i            : 0 level, 1 rising, 2 falling, 3 any change
//   trig_mask_i/value_i    : trigger bit select / level pattern
//   trig_count_i           : required number of matches (see build option)
//   pretrig_i              : samples kept ahead of the trigger
//   rd_en_i, rd_addr_i     : logical read (0 = oldest sample)
//   rd_data_o              : read sample, one cycle after rd_en_i
//   state_o, done_o        : FSM state (IDLE=0..DONE=4), capture complete
//   trig_pos_o             : RAM address of the trigger sample
//
// Build option
//   LA_TRIG_COUNT_EN : when defined, the trigger fires on the Nth match in
//                      WAIT (N = latched trig_count_i, 0 treated as 1);
//                      otherwise it fires on the first match and
//                      trig_count_i is ignored.
// -----------------------------------------------------------------------------
module la_capture_core
    import la_pkg::*;
#(
    parameter  int PROBE_W = 7,
    parameter  int DEPTH   = 1024,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [PROBE_W-1:0] probe_i,
    input  logic               arm_i,
    input  logic [1:0]         trig_mode_i,
    input  logic [PROBE_W-1:0] trig_mask_i,
    input  logic [PROBE_W-1:0] trig_value_i,
    input  logic [7:0]         trig_count_i,
    input  logic [AW-1:0]      pretrig_i,
    input  logic               rd_en_i,
    input  logic [AW-1:0]      rd_addr_i,
    output logic [PROBE_W-1:0] rd_data_o,
    output logic [2:0]         state_o,
    output logic               done_o,
    output logic [AW-1:0]      trig_pos_o
);

    la_state_e          state_q, state_d;

    la_trig_mode_e      mode_q;
    logic [PROBE_W-1:0] mask_q, value_q;
    logic [AW-1:0]      pretrig_q;

    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      cnt_q;
    logic [AW-1:0]      trig_pos_q;
    logic [AW-1:0]      post_last;

    logic [PROBE_W-1:0] probe_p1;
    logic               vld_p1;

    logic               wr_en;
    logic               hit;
    logic               fire;

    function automatic logic trig_hit(
        input la_trig_mode_e      mode,
        input logic [PROBE_W-1:0] mask,
        input logic [PROBE_W-1:0] value,
        input logic [PROBE_W-1:0] cur,
        input logic [PROBE_W-1:0] prev,
        input logic               prev_vld
    );
        logic r;
        r = 1'b0;
        case (mode)
            TRIG_LEVEL: r = ((cur & mask) == (value & mask));
            TRIG_RISE:  r = prev_vld && (|(mask & cur & ~prev));
            TRIG_FALL:  r = prev_vld && (|(mask & ~cur & prev));
            TRIG_ANY:   r = prev_vld && (|(mask & (cur ^ prev)));
            default:    r = 1'b0;
        endcase
        return r;
    endfunction

    // Last value of cnt_q in POST: the trigger sample is the first of the
    // DEPTH - pretrig post samples, so POST writes DEPTH - pretrig - 1 more.
    assign post_last = {AW{1'b1}} - pretrig_q;
    assign hit       = trig_hit(mode_q, mask_q, value_q, probe_i, probe_p1, vld_p1);

`ifdef LA_TRIG_COUNT_EN
    logic [7:0] count_q;
    logic [7:0] match_cnt_q;
    logic [7:0] need_m1;

    assign need_m1 = (count_q == 8'd0) ? 8'd0 : count_q - 8'd1;
    assign fire    = hit && (match_cnt_q >= need_m1);

    always_ff @(posedge clk_i) begin
        if (arm_i) begin
            count_q <= trig_count_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            match_cnt_q <= '0;
        end else if (arm_i) begin
            match_cnt_q <= '0;
        end else if (state_q == ST_WAIT && hit && match_cnt_q != 8'hFF) begin
            match_cnt_q <= match_cnt_q + 8'd1;
        end
    end
`else
    logic trig_count_unused;
    assign trig_count_unused = ^trig_count_i;
    assign fire              = hit;
`endif

    // Trigger configuration: held from one arm to the next.
    always_ff @(posedge clk_i) begin
        if (arm_i) begin
            mode_q    <= la_trig_mode_e'(trig_mode_i);
            mask_q    <= trig_mask_i;
            value_q   <= trig_value_i;
            pretrig_q <= pretrig_i;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        if (arm_i) begin
            state_d = (pretrig_i == '0) ? ST_WAIT : ST_PRE;
        end else begin
            case (state_q)
                ST_PRE:  if (cnt_q == pretrig_q - AW'(1)) state_d = ST_WAIT;
                ST_WAIT: if (fire) state_d = (post_last == '0) ? ST_DONE : ST_POST;
                ST_POST: if (cnt_q == post_last) state_d = ST_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    // FSM outputs; the arm cycle itself is never written.
    always_comb begin
        wr_en   = 1'b0;
        done_o  = 1'b0;
        state_o = state_q;
        case (state_q)
            ST_PRE, ST_WAIT, ST_POST: wr_en = !arm_i;
            ST_DONE:                  done_o = 1'b1;
            default:                  wr_en = 1'b0;
        endcase
    end

    // Pointers and counters. cnt_q counts PRE samples, rests at 0 in WAIT,
    // then counts POST samples starting from the trigger sample.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            trig_pos_q <= '0;
            vld_p1     <= 1'b0;
        end else if (arm_i) begin
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            vld_p1   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
                vld_p1   <= 1'b1;
            end
            case (state_q)
                ST_PRE:  cnt_q <= (cnt_q == pretrig_q - AW'(1)) ? '0 : cnt_q + AW'(1);
                ST_WAIT: begin
                    if (fire) begin
                        trig_pos_q <= wr_ptr_q;
                        cnt_q      <= AW'(1);
                    end
                end
                ST_POST: cnt_q <= cnt_q + AW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Stage p1: previous written sample for edge detection
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            probe_p1 <= probe_i;
        end
    end

    assign trig_pos_o = trig_pos_q;

    la_capture_core_if #(.PROBE_W(PROBE_W), .DEPTH(DEPTH)) ram_bus ();

    assign ram_bus.we    = wr_en;
    assign ram_bus.waddr = wr_ptr_q;
    assign ram_bus.wdata = probe_i;
    assign ram_bus.re    = rd_en_i;
    // Logical 0 is the oldest sample, pretrig entries ahead of the trigger.
    assign ram_bus.raddr = trig_pos_q - pretrig_q + rd_addr_i;
    assign rd_data_o     = ram_bus.rdata;

    la_capture_ram #(
        .PROBE_W (PROBE_W),
        .DEPTH   (DEPTH)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (ram_bus)
    );

endmodule

// File: tb/tb_la_capture_core.sv
// -----------------------------------------------------------------------------
// tb_la_capture_core -- directed bench for la_capture_core (PROBE_W=7,
// DEPTH=16). Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_la_capture_core;

    localparam int PW = 7;
    localparam int DP = 16;
    localparam int AW = 4;

    logic          clk;
    logic          rst_n;
    logic [PW-1:0] probe;
    logic          arm;
    logic [1:0]    trig_mode;
    logic [PW-1:0] trig_mask;
    logic [PW-1:0] trig_value;
    logic [7:0]    trig_count;
    logic [AW-1:0] pretrig;
    logic [2:0]    state;
    logic          done;
    logic [AW-1:0] trig_pos;

    int tests = 0;
    int fails = 0;

    la_capture_core_if #(.PROBE_W(PW), .DEPTH(DP)) rd_bus ();

    assign rd_bus.we    = 1'b0;
    assign rd_bus.waddr = '0;
    assign rd_bus.wdata = '0;

    la_capture_core #(.PROBE_W(PW), .DEPTH(DP)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .probe_i      (probe),
        .arm_i        (arm),
        .trig_mode_i  (trig_mode),
        .trig_mask_i  (trig_mask),
        .trig_value_i (trig_value),
        .trig_count_i (trig_count),
        .pretrig_i    (pretrig),
        .rd_en_i      (rd_bus.re),
        .rd_addr_i    (rd_bus.raddr),
        .rd_data_o    (rd_bus.rdata),
        .state_o      (state),
        .done_o       (done),
        .trig_pos_o   (trig_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input logic [1:0] mode, input logic [PW-1:0] mask,
                          input logic [PW-1:0] value, input logic [7:0] cnt,
                          input logic [AW-1:0] pre);
        arm        = 1'b1;
        trig_mode  = mode;
        trig_mask  = mask;
        trig_value = value;
        trig_count = cnt;
        pretrig    = pre;
        tick();
        arm        = 1'b0;
    endtask

    task automatic sample(input logic [PW-1:0] v);
        probe = v;
        tick();
    endtask

    task automatic rd(input logic [AW-1:0] addr);
        rd_bus.re    = 1'b1;
        rd_bus.raddr = addr;
        tick();
        rd_bus.re    = 1'b0;
    endtask

    initial begin
        logic [PW-1:0] v;
        rst_n        = 1'b1;
        arm          = 1'b0;
        probe        = '0;
        trig_mode    = '0;
        trig_mask    = '0;
        trig_value   = '0;
        trig_count   = '0;
        pretrig      = '0;
        rd_bus.re    = 1'b0;
        rd_bus.raddr = '0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_trig_pos", 32'(trig_pos), 32'd0);
        check("rst_rd_data", 32'(rd_bus.rdata), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("idle_after_rst", 32'(state), 32'd0);

        // Level trigger: pretrig 4, even counts, 0x41 at sample 10
        do_arm(2'd0, 7'h01, 7'h01, 8'd0, 4'd4);
        check("lvl_pre_state", 32'(state), 32'd1);
        for (int k = 0; k < 22; k++) begin
            v = (k == 10) ? 7'h41 : 7'(2 * k);
            sample(v);
            if (k == 3)  check("lvl_wait_after_pre", 32'(state), 32'd2);
            if (k == 9)  check("lvl_no_trig_even", 32'(state), 32'd2);
            if (k == 10) begin
                check("lvl_post_state", 32'(state), 32'd3);
                check("lvl_trig_pos", 32'(trig_pos), 32'd10);
            end
            if (k == 20) check("lvl_not_done_yet", 32'(done), 32'd0);
            if (k == 21) begin
                check("lvl_done", 32'(done), 32'd1);
                check("lvl_done_state", 32'(state), 32'd4);
            end
        end
        rd(4'd4);
        check("lvl_rd4", 32'(rd_bus.rdata), 32'h41);
        rd(4'd0);
        check("lvl_rd0", 32'(rd_bus.rdata), 32'h0C);
        rd(4'd11);
        check("lvl_rd11", 32'(rd_bus.rdata), 32'h22);
        rd_bus.raddr = 4'd4;
        tick();
        check("lvl_rd_hold", 32'(rd_bus.rdata), 32'h22);

        // Rising edge: bit 2 already high at arm
        probe = 7'h04;
        do_arm(2'd1, 7'h04, 7'h00, 8'd0, 4'd0);
        check("rise_wait_state", 32'(state), 32'd2);
        sample(7'h04);
        check("rise_no_trig_s0", 32'(state), 32'd2);
        sample(7'h04);
        sample(7'h01);
        sample(7'h00);
        check("rise_no_trig_unmasked", 32'(state), 32'd2);
        sample(7'h04);
        check("rise_post_state", 32'(state), 32'd3);
        check("rise_trig_pos", 32'(trig_pos), 32'd4);

        // Re-arm during POST
        sample(7'h00);
        sample(7'h00);
        do_arm(2'd0, 7'h01, 7'h01, 8'd0, 4'd2);
        check("rearm_pre_state", 32'(state), 32'd1);
        sample(7'h00);
        check("rearm_pre_s0", 32'(state), 32'd1);
        sample(7'h01);
        check("rearm_pre_ignored", 32'(state), 32'd2);
        for (int k = 2; k < 6; k++) sample(7'h00);
        check("rearm_wait", 32'(state), 32'd2);
        sample(7'h01);
        check("rearm_post_state", 32'(state), 32'd3);
        check("rearm_trig_pos", 32'(trig_pos), 32'd6);

        // Wrap-around: pretrig 12, trigger lands at physical address 3
        do_arm(2'd0, 7'h7F, 7'h55, 8'd0, 4'd12);
        for (int k = 0; k < 23; k++) begin
            v = (k == 19) ? 7'h55 : 7'(k);
            sample(v);
            if (k == 11) check("wrap_wait_state", 32'(state), 32'd2);
            if (k == 18) check("wrap_no_trig", 32'(state), 32'd2);
            if (k == 19) check("wrap_trig_pos", 32'(trig_pos), 32'd3);
            if (k == 21) check("wrap_not_done", 32'(done), 32'd0);
            if (k == 22) check("wrap_done", 32'(done), 32'd1);
        end
        sample(7'h7F);
        rd(4'd0);
        check("wrap_rd0", 32'(rd_bus.rdata), 32'h07);
        rd(4'd15);
        check("wrap_rd15", 32'(rd_bus.rdata), 32'h16);
        rd(4'd12);
        check("wrap_rd12", 32'(rd_bus.rdata), 32'h55);

        // Reset while waiting for the trigger
        do_arm(2'd0, 7'h01, 7'h01, 8'd0, 4'd0);
        sample(7'h00);
        check("rstw_wait_state", 32'(state), 32'd2);
        rst_n = 1'b0;
        #1;
        check("rstw_state", 32'(state), 32'd0);
        check("rstw_done", 32'(done), 32'd0);
        check("rstw_trig_pos", 32'(trig_pos), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        sample(7'h01);
        sample(7'h01);
        sample(7'h01);
        check("rstw_ignored_state", 32'(state), 32'd0);
        check("rstw_ignored_pos", 32'(trig_pos), 32'd0);
        do_arm(2'd0, 7'h01, 7'h01, 8'd0, 4'd0);
        check("rstw_rearm_state", 32'(state), 32'd2);
        sample(7'h01);
        check("rstw_rearm_trig", 32'(state), 32'd3);

        // Trigger count: matches on samples 5, 8 and 9, count 3
        do_arm(2'd0, 7'h01, 7'h01, 8'd3, 4'd0);
        for (int k = 0; k < 10; k++) begin
            v = (k == 5 || k == 8 || k == 9) ? 7'h01 : 7'h00;
            sample(v);
`ifdef LA_TRIG_COUNT_EN
            if (k == 5) check("cnt_first_match", 32'(state), 32'd2);
            if (k == 8) check("cnt_second_match", 32'(state), 32'd2);
            if (k == 9) begin
                check("cnt_third_state", 32'(state), 32'd3);
                check("cnt_trig_pos", 32'(trig_pos), 32'd9);
            end
`else
            if (k == 4) check("cnt_no_match", 32'(state), 32'd2);
            if (k == 5) begin
                check("cnt_first_state", 32'(state), 32'd3);
                check("cnt_trig_pos", 32'(trig_pos), 32'd5);
            end
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
